// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - step sequencer with single-shot/loop modes and one-hot step selector
module step_sequencer #(
  parameter int STEP_W   = 4,
  parameter int MAX_STEP = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   advance,
  input  logic                   clear,
  input  logic                   single,
  input  logic [STEP_W-1:0]      last_step,
  output logic [STEP_W-1:0]      step,
  output logic [2**STEP_W-1:0]   selector,
  output logic                   busy,
  output logic                   wrap,
  output logic                   done
);

  localparam int SEL_W = 2**STEP_W;
  localparam logic [STEP_W-1:0] MAX_S = STEP_W'(MAX_STEP);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_n;
  logic [STEP_W-1:0]  step_n;
  logic [SEL_W-1:0]   selector_n;
  logic [STEP_W-1:0]  eff_last, eff_last_n;
  logic               mode_single, mode_single_n;
  logic               wrap_n, done_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      step        <= '0;
      selector    <= '0;
      wrap        <= 1'b0;
      done        <= 1'b0;
      eff_last    <= '0;
      mode_single <= 1'b0;
    end else begin
      state       <= state_n;
      step        <= step_n;
      selector    <= selector_n;
      wrap        <= wrap_n;
      done        <= done_n;
      eff_last    <= eff_last_n;
      mode_single <= mode_single_n;
    end
  end

  always_comb begin
    state_n       = state;
    step_n        = step;
    eff_last_n    = eff_last;
    mode_single_n = mode_single;
    wrap_n        = 1'b0;
    done_n        = 1'b0;
    if (clear) begin
      state_n = IDLE;
      step_n  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_n       = RUN;
            step_n        = '0;
            eff_last_n    = (last_step > MAX_S) ? MAX_S : last_step;
            mode_single_n = single;
          end
        end
        RUN: begin
          if (advance) begin
            // >= rather than == keeps step bounded even if eff_last were ever undershot
            if (step >= eff_last) begin
              step_n = '0;
              if (mode_single) begin
                state_n = IDLE;
                done_n  = 1'b1;
              end else begin
                wrap_n = 1'b1;
              end
            end else begin
              step_n = step + STEP_W'(1);
            end
          end
        end
        default: begin
          state_n = IDLE;
          step_n  = '0;
        end
      endcase
    end
    selector_n = (state_n == RUN) ? (SEL_W'(1) << step_n) : '0;
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_step_sequencer.sv
// tb/tb_step_sequencer.sv - directed bench for step_sequencer with per-cycle reference model
module tb_step_sequencer;

  localparam int STEP_W = 4;
  localparam int MAX    = 8;
  localparam int SEL_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              advance = 1'b0;
  logic              clear = 1'b0;
  logic              single = 1'b0;
  logic [STEP_W-1:0] last_step = '0;
  logic [STEP_W-1:0] step;
  logic [SEL_W-1:0]  selector;
  logic              busy, wrap, done;

  int errors = 0;
  int checks = 0;

  step_sequencer #(.STEP_W(STEP_W), .MAX_STEP(MAX)) dut (
    .clk(clk), .rst(rst), .start(start), .advance(advance), .clear(clear),
    .single(single), .last_step(last_step), .step(step), .selector(selector),
    .busy(busy), .wrap(wrap), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: a running flag plus integer step position
  int m_run = 0, m_step = 0, m_last = 0, m_single = 0, m_wrap = 0, m_done = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 0; m_step = 0; m_last = 0; m_single = 0; m_wrap = 0; m_done = 0;
    end else begin
      m_wrap = 0;
      m_done = 0;
      if (clear) begin
        m_run = 0;
        m_step = 0;
      end else if (m_run == 0) begin
        if (start) begin
          m_run = 1;
          m_step = 0;
          m_last = (int'(last_step) > MAX) ? MAX : int'(last_step);
          m_single = int'(single);
        end
      end else if (advance) begin
        if (m_step < m_last) m_step = m_step + 1;
        else begin
          m_step = 0;
          if (m_single != 0) begin m_run = 0; m_done = 1; end
          else m_wrap = 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [SEL_W-1:0] exp_sel;
  always @(negedge clk) begin
    exp_sel = (m_run != 0) ? (SEL_W'(1) << m_step) : '0;
    chk("model_step", 32'(step), 32'(m_step));
    chk("model_selector", 32'(selector), 32'(exp_sel));
    chk("model_busy", 32'(busy), 32'(m_run));
    chk("model_wrap", 32'(wrap), 32'(m_wrap));
    chk("model_done", 32'(done), 32'(m_done));
    chk("wrap_done_excl", 32'(wrap & done), 32'h0);
    chk("sel_above_max", 32'(selector >> (MAX + 1)), 32'h0);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_clear();
    clear = 1'b1; advance = 1'b0; start = 1'b0;
    tick();
    clear = 1'b0;
  endtask

  int exp_steps [10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
  int exp_wraps [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) tick();
    chk("reset_step", 32'(step), 32'h0);
    chk("reset_sel", 32'(selector), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);

    // single-shot walk to 8, first start right after reset release
    rst = 1'b0; last_step = 4'd8; single = 1'b1; start = 1'b1; advance = 1'b1;
    tick();
    chk("start_busy", 32'(busy), 32'h1);
    chk("start_sel", 32'(selector), 32'h0001);
    start = 1'b0;
    repeat (8) tick();
    chk("walk_top_sel", 32'(selector), 32'h0100);
    chk("walk_top_step", 32'(step), 32'h8);
    tick();
    chk("walk_done", 32'(done), 32'h1);
    chk("walk_done_sel", 32'(selector), 32'h0);
    chk("walk_done_busy", 32'(busy), 32'h0);
    tick();
    chk("done_one_cycle", 32'(done), 32'h0);

    // loop mode, last_step=3
    last_step = 4'd3; single = 1'b0; start = 1'b1; advance = 1'b0;
    tick();
    start = 1'b0; advance = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("loop_step", 32'(step), 32'(exp_steps[i]));
      chk("loop_wrap", 32'(wrap), 32'(exp_wraps[i]));
      tick();
    end
    do_clear();

    // clamp last_step=12 to 8
    last_step = 4'd12; single = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; advance = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("clamp_sel", 32'(selector <= 16'h0100), 32'h1);
      tick();
    end
    do_clear();

    // hold at 5, last_step change during RUN ignored
    last_step = 4'd8; single = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; advance = 1'b1;
    repeat (5) tick();
    advance = 1'b0; last_step = 4'd2;
    repeat (3) tick();
    chk("hold_step", 32'(step), 32'h5);
    advance = 1'b1;
    repeat (3) tick();
    chk("latched_step", 32'(step), 32'h8);
    tick();
    chk("latched_done", 32'(done), 32'h1);

    // clear together with advance at step 4
    last_step = 4'd8; single = 1'b1; start = 1'b1; advance = 1'b0;
    tick();
    start = 1'b0; advance = 1'b1;
    repeat (4) tick();
    chk("pre_clear_step", 32'(step), 32'h4);
    clear = 1'b1;
    tick();
    clear = 1'b0; advance = 1'b0;
    chk("clear_busy", 32'(busy), 32'h0);
    chk("clear_sel", 32'(selector), 32'h0);
    chk("clear_nopulse", 32'({wrap, done}), 32'h0);

    // asynchronous reset between edges at step 6
    start = 1'b1;
    tick();
    start = 1'b0; advance = 1'b1;
    repeat (6) tick();
    chk("pre_rst_step", 32'(step), 32'h6);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_sel", 32'(selector), 32'h0);
    chk("async_rst_step", 32'(step), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_idle", 32'(busy), 32'h0);
    chk("post_rst_nodone", 32'(done), 32'h0);

    // start during RUN ignored
    last_step = 4'd8; single = 1'b0; start = 1'b1; advance = 1'b0;
    tick();
    start = 1'b0; advance = 1'b1;
    repeat (2) tick();
    start = 1'b1;
    tick();
    chk("start_in_run", 32'(step), 32'h3);
    start = 1'b0;
    do_clear();

    // eff_last=0 single-shot, start held high across the done edge
    last_step = 4'd0; single = 1'b1; start = 1'b1; advance = 1'b0;
    tick();
    advance = 1'b1;
    tick();
    chk("zero_single_done", 32'(done), 32'h1);
    chk("zero_single_busy", 32'(busy), 32'h0);
    tick();
    chk("restart_after_done", 32'(busy), 32'h1);
    start = 1'b0;
    do_clear();

    // eff_last=0 loop: wrap on every advance
    last_step = 4'd0; single = 1'b0; start = 1'b1; advance = 1'b0;
    tick();
    start = 1'b0; advance = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("zero_loop_wrap", 32'(wrap), 32'h1);
      chk("zero_loop_step", 32'(step), 32'h0);
    end
    do_clear();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/step_sequencer.md
STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 Parameter STEP_W, default 4: width of step index; selector width is 2**STEP_W.
REQ-002 Parameter MAX_STEP, default 8: highest step ever reachable; SHALL satisfy MAX_STEP < 2**STEP_W.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  begin a sequence from step 0 (sampled in IDLE only).
REQ-006 advance  input  1  step enable; when low in RUN the step holds.
REQ-007 clear  input  1  synchronous abort to IDLE.
REQ-008 single  input  1  mode: 1 = single-shot, 0 = free-running loop; latched at start.
REQ-009 last_step  input  STEP_W  programmable final step; latched at start.
REQ-010 step  output  STEP_W  current step index, registered.
REQ-011 selector  output  2**STEP_W  one-hot decode of step while running, registered.
REQ-012 busy  output  1  high while in RUN.
REQ-013 wrap  output  1  one-cycle pulse on loop-mode return to step 0.
REQ-014 done  output  1  one-cycle pulse on single-shot completion.

Function
REQ-015 FSM states: IDLE, RUN; no other states.
REQ-016 IDLE: step=0, selector=all zeros, busy=0.
REQ-017 IDLE and start=1 and clear=0 at edge k: after edge k state=RUN, step=0, selector=bit 0 only, busy=1; latency one cycle.
REQ-018 At start, eff_last SHALL latch min(last_step, MAX_STEP) and mode SHALL latch single; changes to last_step/single during RUN have no effect.
REQ-019 RUN, advance=0: step, selector, state held; wrap=done=0.
REQ-020 RUN, advance=1, step<eff_last: step increments by 1, selector shifts to matching one-hot bit.
REQ-021 RUN, advance=1, step==eff_last, loop mode: step=0, selector=bit 0, stays RUN, wrap=1 for that one cycle.
REQ-022 RUN, advance=1, step==eff_last, single-shot: state=IDLE, step=0, selector=0, busy=0, done=1 for that one cycle.
REQ-023 eff_last=0: every advance in RUN is a final step (loop: wrap every advance with step remaining 0; single: done on first advance).
REQ-024 start while in RUN SHALL be ignored.
REQ-025 clear=1 at any edge: state=IDLE, step=0, selector=0, busy=0, wrap=0, done=0; clear has priority over start and advance.
REQ-026 selector SHALL always be either all zeros (IDLE) or exactly one bit set equal to bit index step (RUN); never multi-hot.
REQ-027 step SHALL never exceed eff_last; bits of selector above MAX_STEP SHALL never assert.
REQ-028 wrap and done SHALL never assert in the same cycle and SHALL never assert for two consecutive cycles from one event.
REQ-029 The same-edge transition from done back to RUN is not permitted; a new start is accepted only at an edge where the FSM is already in IDLE.

Reset
REQ-030 rst=1 asynchronously forces IDLE, step=0, selector=0, busy=0, wrap=0, done=0, eff_last=0, mode=loop, independent of clk.
REQ-031 rst asserted mid-sequence SHALL abort without a done or wrap pulse; after release the block waits in IDLE for start.
REQ-032 First start is accepted at the first rising edge after rst deasserts.

Verification
REQ-033 Default params, last_step=8, single=1, start then advance held high: selector walks 0x0001,0x0002,...,0x0100 over 9 cycles; next edge done=1, selector=0x0000, busy=0.
REQ-034 last_step=3, single=0, advance high 10 cycles: step sequence 0,1,2,3,0,1,2,3,0,1; wrap=1 exactly on the two returns to 0.
REQ-035 last_step=12 (>MAX_STEP): clamps to 8; selector never exceeds 0x0100.
REQ-036 Run at step 5, toggle advance low 3 cycles, change last_step to 2: step holds at 5, then continues to 8 using the latched value.
REQ-037 clear and advance together at step 4: next cycle IDLE, selector=0x0000, no done/wrap; rst pulsed asynchronously between edges at step 6: outputs zero immediately.
REQ-038 start asserted during RUN at step 2: ignored, step continues 3 on next advance; last_step=0 single-shot: done on first advance.
